mem_wb_skid_latch: RTL
======================

Name: mem_wb_skid_latch

Overview:
- Parametrised MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
- Supports stall from WB or the register file, and flush.
- Applies a RegWrite suppression rule for register 0.
- Sits between the MEM stage and the WB stage and also produces the final write-back data mux output.

Parameters:
- DATA_W, 32, width of the ALU result, read data and write-back data.
- REG_W, 5, width of the destination register index.
- WBC_W, 2, width of the WB control bundle; bit 1 = RegWrite, bit 0 = MemtoReg; bits above 1 pass through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush: drops all held and incoming entries.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  latch can accept an entry this cycle.
- ALUResult_in  in  DATA_W  ALU result.
- ReadData_in  in  DATA_W  data-memory read data.
- WriteReg_in  in  REG_W  destination register.
- WBControl_in  in  WBC_W  WB control bundle.
- out_valid  out  1  head entry valid toward WB.
- out_ready  in  1  WB consumes the head entry this cycle.
- ALUResult_out  out  DATA_W  head ALU result.
- ReadData_out  out  DATA_W  head read data.
- WriteReg_out  out  REG_W  head destination register.
- WBControl_out  out  WBC_W  head control, after the reg-0 rule.
- WriteData_out  out  DATA_W  combinational: ReadData_out if WBControl_out[0] else ALUResult_out.
- RegWrite_out  out  1  WBControl_out[1] & out_valid.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- Storage:
  - head register H (drives all *_out ports) with valid bit hv.
  - skid register S with valid bit sv.
  - States: EMPTY (hv=0, sv=0), ONE (hv=1, sv=0), FULL (hv=1, sv=1). hv=0 with sv=1 is illegal and never reached.
- Reset (rst_n=0, asynchronous):
  - hv=sv=0; all data and control regs = 0.
  - Hence out_valid=0, RegWrite_out=0, WriteData_out=0, occupancy=0, in_ready=1.
- in_ready = !sv, derived from a registered bit only; no combinational path from out_ready.
- acc = in_valid & in_ready; deq = hv & out_ready.
- Capture rule: if WriteReg_in == 0, bit 1 of the captured WBControl is forced to 0. All other fields are captured unmodified.
- Transitions when flush=0:
  - EMPTY: acc → H=in, ONE.
  - ONE, acc & deq → H=in, ONE.
  - ONE, acc & !deq → S=in, FULL.
  - ONE, !acc & deq → EMPTY.
  - ONE, neither → hold.
  - FULL, deq → H=S, sv=0, ONE. in_ready=0 this cycle, so no acc.
  - FULL, !deq → hold.
- Latency:
  - An entry accepted at edge N is visible on the outputs after edge N.
  - One entry per cycle sustained while out_ready=1.
  - Entries leave strictly in acceptance order.
- Flush (flush=1 at an edge):
  - hv=sv=0 after the edge.
  - Any acc that cycle is discarded.
  - Flush overrides acc and deq; data regs may keep stale values.
  - out_valid=0 from the next cycle.
- Outputs when hv=0: out_valid=0 and RegWrite_out=0. Data ports hold their last values and are don't-care.
- Data stability: while out_valid=1 and out_ready=0, all *_out ports are stable.
- occupancy = hv + sv.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

Test Plan:
1. Reset, then accept {ALU=32'h12345678, RD=32'hABCDEF01, WR=5'h1F, WBC=2'b10} with out_ready=1.
   → After 1 edge: out_valid=1, WriteData_out=32'h12345678, RegWrite_out=1, occupancy=1.
2. Back-to-back stream with out_ready=0: accept A (WBC=2'b01, RD=32'hFEDCBA98), then B.
   → occupancy=2, in_ready=0, a third entry is not accepted, outputs show A with WriteData_out=32'hFEDCBA98.
   → Raise out_ready: A, then B, appear on consecutive cycles; in_ready returns to 1 once B is head.
3. Accept WR=5'h00, WBC=2'b11.
   → WBControl_out=2'b01, RegWrite_out=0, WriteData_out=ReadData_out.
4. In FULL state, assert flush together with in_valid=1.
   → Next cycle: out_valid=0, occupancy=0, in_ready=1; the flushed input never appears at the outputs.
5. Pulse rst_n low between clock edges while in state ONE.
   → out_valid, occupancy and RegWrite_out drop to 0 immediately, before the next clk edge.
6. Sustained stream of 8 entries (ALU=i) with out_ready toggling 1,0,1,0,...
   → All 8 exit in order with no loss or duplication; outputs stay stable during every cycle with out_ready=0.

Source files
------------

// File: rtl/mem_wb_skid_latch.sv
// MEM/WB pipeline register with a 2-entry skid buffer (head H + skid S).
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and in_ready depends only on the
// registered skid-valid bit, so there is no combinational out_ready->in_ready path.
// Destination register 0 never carries RegWrite (bit 1 of the WB control bundle).
// The head register also feeds the final write-back data mux.
module mem_wb_skid_latch #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WBC_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] ReadData_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  input  logic [WBC_W-1:0]  WBControl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic [WBC_W-1:0]  WBControl_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic              RegWrite_out,
  output logic [1:0]        occupancy
);

  // EMPTY: hv=0 sv=0, ONE: hv=1 sv=0, FULL: hv=1 sv=1
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] h_alu_q, h_alu_d, s_alu_q, s_alu_d;
  logic [DATA_W-1:0] h_rd_q,  h_rd_d,  s_rd_q,  s_rd_d;
  logic [REG_W-1:0]  h_wr_q,  h_wr_d,  s_wr_q,  s_wr_d;
  logic [WBC_W-1:0]  h_wbc_q, h_wbc_d, s_wbc_q, s_wbc_d;

  logic             hv, sv, acc, deq;
  logic [WBC_W-1:0] wbc_cap;

  assign hv  = (state_q != ST_EMPTY);
  assign sv  = (state_q == ST_FULL);
  assign acc = in_valid & in_ready;
  assign deq = hv & out_ready;

  // Incoming control with RegWrite cleared for destination register 0
  always_comb begin
    wbc_cap = WBControl_in;
    if (WriteReg_in == '0) wbc_cap[1] = 1'b0;
  end

  // Next-state and next-data: flush dominates, otherwise move entries head-first
  always_comb begin
    state_d = state_q;
    h_alu_d = h_alu_q;
    h_rd_d  = h_rd_q;
    h_wr_d  = h_wr_q;
    h_wbc_d = h_wbc_q;
    s_alu_d = s_alu_q;
    s_rd_d  = s_rd_q;
    s_wr_d  = s_wr_q;
    s_wbc_d = s_wbc_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            h_alu_d = ALUResult_in;
            h_rd_d  = ReadData_in;
            h_wr_d  = WriteReg_in;
            h_wbc_d = wbc_cap;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            h_alu_d = ALUResult_in;
            h_rd_d  = ReadData_in;
            h_wr_d  = WriteReg_in;
            h_wbc_d = wbc_cap;
          end else if (acc) begin
            s_alu_d = ALUResult_in;
            s_rd_d  = ReadData_in;
            s_wr_d  = WriteReg_in;
            s_wbc_d = wbc_cap;
            state_d = ST_FULL;
          end else if (deq) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid-to-head move can happen
          if (deq) begin
            h_alu_d = s_alu_q;
            h_rd_d  = s_rd_q;
            h_wr_d  = s_wr_q;
            h_wbc_d = s_wbc_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      h_alu_q <= '0;
      h_rd_q  <= '0;
      h_wr_q  <= '0;
      h_wbc_q <= '0;
      s_alu_q <= '0;
      s_rd_q  <= '0;
      s_wr_q  <= '0;
      s_wbc_q <= '0;
    end else begin
      state_q <= state_d;
      h_alu_q <= h_alu_d;
      h_rd_q  <= h_rd_d;
      h_wr_q  <= h_wr_d;
      h_wbc_q <= h_wbc_d;
      s_alu_q <= s_alu_d;
      s_rd_q  <= s_rd_d;
      s_wr_q  <= s_wr_d;
      s_wbc_q <= s_wbc_d;
    end
  end

  assign in_ready      = ~sv;
  assign out_valid     = hv;
  assign ALUResult_out = h_alu_q;
  assign ReadData_out  = h_rd_q;
  assign WriteReg_out  = h_wr_q;
  assign WBControl_out = h_wbc_q;
  assign WriteData_out = h_wbc_q[0] ? h_rd_q : h_alu_q;
  assign RegWrite_out  = h_wbc_q[1] & hv;
  assign occupancy     = {sv, hv & ~sv};

endmodule
